// File: rtl/vic_irq_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vic_irq_dispatch_pkg
// Description : Shared constants, FSM encoding and helpers for the VIC
//               IRQ dispatch block.
// Revision    : 1.0 - initial release
// ============================================================================
package vic_irq_dispatch_pkg;

    localparam int unsigned c_is_w   = 17;
    localparam int unsigned c_nv_bit = 16;
    localparam int unsigned c_idx_w  = 5;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_req  = 2'd1;
    localparam state_t c_st_vec  = 2'd2;

    // Index values >= c_is_w (the "none set" code) map to an all-zero mask.
    function automatic logic [c_is_w-1:0] f_onehot(input logic [c_idx_w-1:0] idx);
        logic [c_is_w-1:0] mask;
        mask = '0;
        if (idx < c_idx_w'(c_is_w)) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

endpackage : vic_irq_dispatch_pkg
`default_nettype wire

// File: rtl/vic_prio_find.sv
`default_nettype none
// ============================================================================
// Module      : vic_prio_find
// Description : Combinational lowest-set-bit finder over the in-service set.
// Revision    : 1.0 - initial release
// ============================================================================
module vic_prio_find
    import vic_irq_dispatch_pkg::*;
(
    input  logic [c_is_w-1:0]  i_vec,
    output logic [c_idx_w-1:0] o_idx,
    output logic               o_none
);

    // Scanning from the top down leaves the lowest set index; none set yields 17.
    always_comb begin
        o_idx = c_idx_w'(c_is_w);
        for (int i = c_is_w - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = c_idx_w'(i);
            end
        end
    end

    assign o_none = ~|i_vec;

endmodule : vic_prio_find
`default_nettype wire

// File: rtl/vic_irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : vic_irq_dispatch
// Description : CPU-side IRQ handshake, vector generation, source clearing
//               and nested in-service tracking with EOI retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module vic_irq_dispatch
    import vic_irq_dispatch_pkg::*;
#(
    parameter logic [31:0] VEC_BASE        = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE_LOG2 = 2,
    parameter logic [31:0] NV_VECTOR       = 32'h0000_0018
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_req,
    input  logic [3:0]        handler_num,
    input  logic              is_nvirq,
    input  logic              cpu_irq_ack,
    input  logic              cpu_eoi,
    output logic              cpu_irq,
    output logic [31:0]       cpu_vector,
    output logic              vector_valid,
    output logic [15:0]       clr_vreq,
    output logic              clr_nvreq,
    output logic [c_is_w-1:0] in_service,
    output logic              eoi_err
);

    state_t              r_state;
    state_t              w_next_state;

    logic [c_is_w-1:0]   r_in_service;
    logic [3:0]          r_cap_num;
    logic                r_cap_nv;
    logic                r_cpu_irq;
    logic                r_vector_valid;
    logic [31:0]         r_cpu_vector;
    logic [15:0]         r_clr_vreq;
    logic                r_clr_nvreq;
    logic                r_eoi_err;

    logic [c_idx_w-1:0]  w_prio;
    logic                w_is_empty;
    logic                w_eligible;
    logic                w_accept;

    logic                w_cpu_irq_nxt;
    logic                w_vector_valid_nxt;
    logic [31:0]         w_cpu_vector_nxt;
    logic [15:0]         w_clr_vreq_nxt;
    logic                w_clr_nvreq_nxt;
    logic [c_is_w-1:0]   w_eoi_clr;
    logic [c_is_w-1:0]   w_vec_set;
    logic [c_is_w-1:0]   w_in_service_nxt;
    logic                w_eoi_err_nxt;

    // The active priority and the EOI target are the same lowest set bit.
    vic_prio_find u_prio_find (
        .i_vec  (r_in_service),
        .o_idx  (w_prio),
        .o_none (w_is_empty)
    );

    assign w_eligible = irq_req & ((~is_nvirq & ({1'b0, handler_num} < w_prio)) |
                                   (is_nvirq & w_is_empty));
    assign w_accept   = (r_state == c_st_req) & cpu_irq_ack & w_eligible;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_in_service   <= '0;
            r_cap_num      <= '0;
            r_cap_nv       <= 1'b0;
            r_cpu_irq      <= 1'b0;
            r_vector_valid <= 1'b0;
            r_cpu_vector   <= '0;
            r_clr_vreq     <= '0;
            r_clr_nvreq    <= 1'b0;
            r_eoi_err      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_in_service   <= w_in_service_nxt;
            r_cpu_irq      <= w_cpu_irq_nxt;
            r_vector_valid <= w_vector_valid_nxt;
            r_cpu_vector   <= w_cpu_vector_nxt;
            r_clr_vreq     <= w_clr_vreq_nxt;
            r_clr_nvreq    <= w_clr_nvreq_nxt;
            r_eoi_err      <= w_eoi_err_nxt;
            if (w_accept) begin
                r_cap_num <= handler_num;
                r_cap_nv  <= is_nvirq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_eligible) begin
                    w_next_state = c_st_req;
                end
            end
            c_st_req: begin
                if (w_accept) begin
                    w_next_state = c_st_vec;
                end else if (!w_eligible) begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_vec: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values for the registered outputs, so every
    // CPU-facing signal comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_irq_nxt      = (w_next_state == c_st_req);
        w_vector_valid_nxt = (w_next_state == c_st_vec);
        w_cpu_vector_nxt   = r_cpu_vector;
        w_clr_vreq_nxt     = '0;
        w_clr_nvreq_nxt    = 1'b0;
        if (w_accept) begin
            if (is_nvirq) begin
                w_cpu_vector_nxt = NV_VECTOR;
                w_clr_nvreq_nxt  = 1'b1;
            end else begin
                w_cpu_vector_nxt = VEC_BASE + (32'(handler_num) << VEC_STRIDE_LOG2);
                w_clr_vreq_nxt   = 16'(32'd1 << handler_num);
            end
        end

        // EOI retires against the pre-update set; the VEC set lands at the same edge.
        w_eoi_clr = (cpu_eoi && !w_is_empty) ? f_onehot(w_prio) : '0;
        w_vec_set = '0;
        if (r_state == c_st_vec) begin
            w_vec_set = f_onehot(r_cap_nv ? c_idx_w'(c_nv_bit) : {1'b0, r_cap_num});
        end
        w_in_service_nxt = (r_in_service & ~w_eoi_clr) | w_vec_set;
        w_eoi_err_nxt    = r_eoi_err | (cpu_eoi & w_is_empty);
    end

    assign cpu_irq      = r_cpu_irq;
    assign cpu_vector   = r_cpu_vector;
    assign vector_valid = r_vector_valid;
    assign clr_vreq     = r_clr_vreq;
    assign clr_nvreq    = r_clr_nvreq;
    assign in_service   = r_in_service;
    assign eoi_err      = r_eoi_err;

endmodule : vic_irq_dispatch
`default_nettype wire

// File: tb/tb_vic_irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vic_irq_dispatch
// Description : Scoreboard bench for vic_irq_dispatch against a set-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vic_irq_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq_req = 1'b0;
    logic [3:0]  handler_num = 4'd0;
    logic        is_nvirq = 1'b0;
    logic        cpu_irq_ack = 1'b0;
    logic        cpu_eoi = 1'b0;
    logic        cpu_irq;
    logic [31:0] cpu_vector;
    logic        vector_valid;
    logic [15:0] clr_vreq;
    logic        clr_nvreq;
    logic [16:0] in_service;
    logic        eoi_err;

    vic_irq_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_req),
        .handler_num  (handler_num),
        .is_nvirq     (is_nvirq),
        .cpu_irq_ack  (cpu_irq_ack),
        .cpu_eoi      (cpu_eoi),
        .cpu_irq      (cpu_irq),
        .cpu_vector   (cpu_vector),
        .vector_valid (vector_valid),
        .clr_vreq     (clr_vreq),
        .clr_nvreq    (clr_nvreq),
        .in_service   (in_service),
        .eoi_err      (eoi_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the set of active interrupts plus the sticky error flag.
    bit m_active [17];
    bit m_err;

    typedef struct {
        logic [31:0] vec;
        logic [15:0] clr_v;
        logic        clr_nv;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_prio();
        for (int i = 0; i < 17; i++) begin
            if (m_active[i]) return i;
        end
        return 17;
    endfunction

    function automatic logic [16:0] m_mask();
        logic [16:0] m;
        m = '0;
        for (int i = 0; i < 17; i++) m[i] = m_active[i];
        return m;
    endfunction

    function automatic bit m_eligible(input int num, input bit nv);
        if (nv) return (m_prio() == 17);
        return (num < m_prio());
    endfunction

    function automatic void m_eoi();
        int p;
        p = m_prio();
        if (p == 17) m_err = 1'b1;
        else m_active[p] = 1'b0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 17; i++) m_active[i] = 1'b0;
        m_err = 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: every vector strobe must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vector_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vector: got vector 0x%0h, expected no vector_valid", cpu_vector);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("cpu_vector", 64'(cpu_vector), 64'(mon_e.vec));
                    check("clr_vreq", 64'(clr_vreq), 64'(mon_e.clr_v));
                    check("clr_nvreq", 64'(clr_nvreq), 64'(mon_e.clr_nv));
                end
            end else if (clr_vreq != 16'd0 || clr_nvreq) begin
                check("stray_clear", 64'({clr_nvreq, clr_vreq}), 64'd0);
            end
        end
    end

    // mode 0: ack, 1: withdraw before ack, 2: ack while eligibility is lost
    task automatic do_req(input int num, input bit nv, input int mode, input bit eoi_in_vec);
        bit          elig;
        logic [31:0] exp_vec;
        exp_t        e;
        elig        = m_eligible(num, nv);
        irq_req     = 1'b1;
        handler_num = 4'(num);
        is_nvirq    = nv;
        tick();
        check("cpu_irq_rise", 64'(cpu_irq), 64'(elig));
        if (!elig) begin
            tick();
            tick();
            check("cpu_irq_held_low", 64'(cpu_irq), 64'd0);
            irq_req  = 1'b0;
            is_nvirq = 1'b0;
            tick();
            return;
        end
        if (mode == 1) begin
            tick();
            check("cpu_irq_hold", 64'(cpu_irq), 64'd1);
            irq_req = 1'b0;
            tick();
            check("cpu_irq_drop", 64'(cpu_irq), 64'd0);
            tick();
            is_nvirq = 1'b0;
            return;
        end
        if (mode == 2) begin
            cpu_irq_ack = 1'b1;
            is_nvirq    = 1'b1;
            tick();
            cpu_irq_ack = 1'b0;
            irq_req     = 1'b0;
            is_nvirq    = 1'b0;
            check("ignored_ack_irq_low", 64'(cpu_irq), 64'd0);
            tick();
            check("ignored_ack_in_service", 64'(in_service), 64'(m_mask()));
            return;
        end
        exp_vec  = nv ? 32'h0000_0018 : 32'h0000_0100 + 32'(num) * 32'd4;
        e.vec    = exp_vec;
        e.clr_v  = nv ? 16'd0 : 16'(32'd1 << num);
        e.clr_nv = nv;
        sb_q.push_back(e);
        if (eoi_in_vec) m_eoi();
        m_active[nv ? 16 : num] = 1'b1;
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        irq_req     = 1'b0;
        is_nvirq    = 1'b0;
        cpu_eoi     = eoi_in_vec;
        check("cpu_irq_in_vec", 64'(cpu_irq), 64'd0);
        tick();
        cpu_eoi = 1'b0;
        check("in_service_after_vec", 64'(in_service), 64'(m_mask()));
        check("eoi_err_after_vec", 64'(eoi_err), 64'(m_err));
        check("cpu_vector_hold", 64'(cpu_vector), 64'(exp_vec));
        check("vector_valid_one_cycle", 64'(vector_valid), 64'd0);
    endtask

    task automatic do_eoi();
        m_eoi();
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
        check("in_service_after_eoi", 64'(in_service), 64'(m_mask()));
        check("eoi_err", 64'(eoi_err), 64'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  op;
        int  num;
        int  mode;
        bit  nv;
        m_reset();
        repeat (3) tick();
        check("reset_cpu_irq", 64'(cpu_irq), 64'd0);
        check("reset_vector", 64'(cpu_vector), 64'd0);
        check("reset_in_service", 64'(in_service), 64'd0);
        check("reset_eoi_err", 64'(eoi_err), 64'd0);
        rst_n = 1'b1;
        tick();

        do_req(5, 1'b0, 0, 1'b0);
        do_req(2, 1'b0, 0, 1'b0);
        do_req(7, 1'b0, 0, 1'b0);
        do_eoi();
        do_req(5, 1'b0, 0, 1'b0);
        do_eoi();
        do_req(0, 1'b1, 0, 1'b0);
        do_req(3, 1'b1, 0, 1'b0);
        do_req(0, 1'b0, 0, 1'b0);
        do_eoi();
        do_eoi();
        do_req(3, 1'b0, 1, 1'b0);
        do_eoi();
        do_eoi();
        do_req(4, 1'b0, 0, 1'b0);
        do_req(1, 1'b0, 0, 1'b1);
        do_req(15, 1'b0, 0, 1'b0);
        do_req(2, 1'b0, 2, 1'b0);
        do_eoi();

        // Asynchronous reset while a request is outstanding.
        irq_req     = 1'b1;
        handler_num = 4'd3;
        tick();
        check("pre_reset_cpu_irq", 64'(cpu_irq), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({cpu_irq, vector_valid, clr_nvreq, clr_vreq, eoi_err}), 64'd0);
        check("async_reset_in_service", 64'(in_service), 64'd0);
        check("async_reset_vector", 64'(cpu_vector), 64'd0);
        m_reset();
        sb_q.delete();
        irq_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 64'(cpu_irq), 64'd0);

        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_eoi();
            end else begin
                num  = $urandom_range(0, 15);
                nv   = ($urandom_range(0, 5) == 0);
                mode = 0;
                op   = $urandom_range(0, 9);
                if (op == 0) mode = 1;
                else if (op == 1 && !nv && m_prio() != 17) mode = 2;
                do_req(num, nv, mode, $urandom_range(0, 4) == 0);
            end
        end

        tick();
        tick();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vic_irq_dispatch
`default_nettype wire
